// File: rtl/ex_div_unit_pkg.sv
// Shared divider constants: data width, op encodings, and FSM states.
// The control decoder and the EX divider both import this package.
package ex_div_unit_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'b00,
        DIV_ST_CALC = 2'b01,
        DIV_ST_FIX  = 2'b10
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? ((~v) + XLEN'(1)) : v;
    endfunction
endpackage

// File: rtl/ex_div_unit_if.sv
// EX-stage divider request/response bundle; master is the pipeline side, slave is the divider.
interface ex_div_unit_if;
    import ex_div_unit_pkg::*;

    logic            flush;
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output flush, start, op, a, b, input busy, done, result);
    modport slave  (input flush, start, op, a, b, output busy, done, result);
endinterface

// File: rtl/ex_div_unit_div_step.sv
// One restoring-division iteration, purely combinational.
// quotient_in doubles as the dividend shift register: its MSB feeds the remainder.
module div_step
    import ex_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] remainder_in,
    input  logic [XLEN-1:0] quotient_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] remainder_out,
    output logic [XLEN-1:0] quotient_out
);
    logic [XLEN:0] shifted;
    logic          borrow;

    assign shifted = {remainder_in, quotient_in[XLEN-1]};
    assign borrow  = (shifted < {1'b0, divisor});

    // The true difference always fits in XLEN bits when there is no borrow.
    assign remainder_out = borrow ? shifted[XLEN-1:0] : (shifted[XLEN-1:0] - divisor);
    assign quotient_out  = {quotient_in[XLEN-2:0], ~borrow};
endmodule

// File: rtl/ex_div_unit.sv
// Iterative 32-bit DIV/DIVU/REM/REMU: 34 cycles start-to-done (2 for /0 and overflow with DIV_EARLY_OUT_EN).
// busy stalls the pipeline; start is ignored while busy; flush aborts without touching result.
module ex_div_unit
    import ex_div_unit_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    ex_div_unit_if.slave  dif
);
    div_state_e      state_q, state_d;
    logic [4:0]      count_q, count_d;
    logic [1:0]      op_q, op_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;
    logic            busy;

    logic            launch, early_out;
    logic            in_neg_a, in_neg_b;
    logic [XLEN-1:0] in_abs_a, in_abs_b;
    logic [XLEN-1:0] step_rem, step_quo;
    logic [XLEN-1:0] q_fix, r_fix;

    assign launch   = (state_q == DIV_ST_IDLE) && dif.start && !dif.flush;
    assign in_neg_a = op_is_signed(dif.op) && dif.a[XLEN-1];
    assign in_neg_b = op_is_signed(dif.op) && dif.b[XLEN-1];
    assign in_abs_a = neg_if(in_neg_a, dif.a);
    assign in_abs_b = neg_if(in_neg_b, dif.b);

`ifdef DIV_EARLY_OUT_EN
    logic in_div_zero, in_ovf;
    assign in_div_zero = (dif.b == '0);
    assign in_ovf      = op_is_signed(dif.op) && (dif.a == 32'h8000_0000) && (dif.b == '1);
    assign early_out   = in_div_zero || in_ovf;
`else
    assign early_out   = 1'b0;
`endif

    div_step u_step (
        .remainder_in  (rem_q),
        .quotient_in   (quo_q),
        .divisor       (divisor_q),
        .remainder_out (step_rem),
        .quotient_out  (step_quo)
    );

    // Divide by zero leaves an all-ones quotient, but the sign fix must not touch it.
    assign q_fix = (divisor_q == '0) ? '1 : neg_if(neg_a_q ^ neg_b_q, quo_q);
    assign r_fix = neg_if(neg_a_q, rem_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= DIV_ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (dif.flush) begin
            state_d = DIV_ST_IDLE;
        end else begin
            case (state_q)
                DIV_ST_IDLE: if (dif.start) state_d = early_out ? DIV_ST_FIX : DIV_ST_CALC;
                DIV_ST_CALC: if (count_q == '0) state_d = DIV_ST_FIX;
                DIV_ST_FIX:  state_d = DIV_ST_IDLE;
                default:     state_d = DIV_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q != DIV_ST_IDLE);
    end

    assign dif.busy   = busy;
    assign dif.done   = done_q;
    assign dif.result = result_q;

    always_comb begin
        count_d   = count_q;
        op_d      = op_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        result_d  = result_q;
        done_d    = 1'b0;
        if (launch) begin
            op_d      = dif.op;
            neg_a_d   = in_neg_a;
            neg_b_d   = in_neg_b;
            divisor_d = in_abs_b;
            rem_d     = '0;
            quo_d     = in_abs_a;
            count_d   = 5'd31;
`ifdef DIV_EARLY_OUT_EN
            // Preload the magnitudes the full iteration would have produced.
            if (in_div_zero) begin
                quo_d = '1;
                rem_d = in_abs_a;
            end else if (in_ovf) begin
                quo_d = 32'h8000_0000;
                rem_d = '0;
            end
`endif
        end else if (!dif.flush && state_q == DIV_ST_CALC) begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q - 5'd1;
        end else if (!dif.flush && state_q == DIV_ST_FIX) begin
            result_d = op_q[1] ? r_fix : q_fix;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            op_q      <= '0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            op_q      <= op_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: doc/ex_div_unit.md
EX_DIV_UNIT -- requirements
Module: ex_div_unit

Interface
REQ-001 The block SHALL be clocked by clk (input, 1 bit, rising edge).
REQ-002 The block SHALL use reset (input, 1 bit): asynchronous, active-high.
REQ-003 flush  input  1  SHALL be a synchronous abort, driven by the same FlushE that clears the ID/EX register.
REQ-004 start  input  1  SHALL request a divide; sampled only in IDLE.
REQ-005 op  input  2  SHALL select the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 a  input  32  SHALL carry the dividend (ALU SrcA in EX).
REQ-007 b  input  32  SHALL carry the divisor (ALU SrcB in EX).
REQ-008 busy  output  1  SHALL be the stall request to the hazard unit.
REQ-009 done  output  1  SHALL be a one-cycle pulse marking result valid.
REQ-010 result  output  32  SHALL hold the quotient or remainder, stable until the next completion.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and FIX.
  - IDLE -> CALC on start; CALC -> FIX after 32 iterations; FIX -> IDLE unconditionally.
REQ-012 On the edge sampling start in IDLE, the block SHALL latch op, the operand signs, |a|, |b|, zero the partial remainder and load count=31.
  - Magnitudes are taken only for DIV/REM.
REQ-013 Each CALC edge SHALL perform one restoring step: shift the remainder left 1 with the next dividend MSB, subtract |b| if no borrow, and shift the quotient bit in.
REQ-014 On the last CALC edge (count=0), the state SHALL move to FIX.
REQ-015 In FIX, the block SHALL load result with the sign-corrected value.
  - DIV: quotient negated if the signs of a and b differ.
  - REM: remainder takes the sign of a.
  - DIVU/REMU: unsigned, no correction.
REQ-016 Normal latency SHALL be fixed: done=1 during the cycle after the 34th rising edge counted from the start-sampling edge (1 capture + 32 CALC + 1 FIX).
REQ-017 busy SHALL be 1 in CALC and FIX, and 0 in the cycle done=1, so the stall releases as the result becomes valid.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 start asserted again in the done cycle SHALL begin a new operation.
REQ-020 Divide by zero SHALL produce DIV/DIVU = 0xFFFFFFFF and REM/REMU = a.
REQ-021 Signed overflow (a=0x80000000, b=0xFFFFFFFF) SHALL produce DIV = 0x80000000 and REM = 0.
REQ-022 flush SHALL have priority over start and FSM progress: next state IDLE, busy=0, done=0, result unchanged.
REQ-023 flush and start in the same IDLE cycle SHALL NOT launch an operation.
REQ-024 Input changes on a/b/op after the start-sampling edge SHALL have no effect on the running operation.

Reset
REQ-025 While reset is high, the block SHALL force: state IDLE, busy=0, done=0, result=0, count=0, and all internal operand and remainder registers to 0.
REQ-026 Reset asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow its release.

Configuration
REQ-027 With the macro DIV_EARLY_OUT_EN defined, divide-by-zero and signed-overflow starts SHALL go IDLE -> FIX directly.
  - done is then high in the cycle after the 2nd rising edge counted from the start-sampling edge.
  - Values are the same as REQ-020/021.
REQ-028 Without DIV_EARLY_OUT_EN, those cases SHALL run the full 32 CALC cycles, with identical results and normal latency per REQ-016.

Structure
REQ-029 A shared package/include SHALL hold:
  - XLEN=32;
  - the op encodings DIV_OP_DIV, DIV_OP_DIVU, DIV_OP_REM, DIV_OP_REMU;
  - the FSM state encodings.
  The control decoder and this block use the same constants.
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring iteration (remainder_in, quotient_in, divisor -> remainder_out, quotient_out).
REQ-031 The top level SHALL contain only the FSM, counter, registers and sign fix-up.

Verification
REQ-032 DIVU a=100, b=7, start one cycle -> busy 1 for 33 cycles, then done=1 with result=14 on the 34th post-start edge.
REQ-033 REM a=-7 (0xFFFFFFF9), b=2 -> result 0xFFFFFFFF; DIV with the same operands -> result 0xFFFFFFFD.
REQ-034 DIV a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - Check latency both with and without DIV_EARLY_OUT_EN.
REQ-035 Start, then flush at CALC cycle 10 -> busy=0 the next cycle, no done pulse, result keeps its previous value; a new start then completes correctly.
REQ-036 Reset asserted at CALC cycle 20 -> all outputs 0 immediately; start while busy is ignored; back-to-back start in the done cycle -> second result correct.
